rv_if_stage: RTL
================

RV_IF_STAGE -- requirements
Module: rv_if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2, SHALL be the number of fetch-queue entries (legal values 2 or 4).
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 imem_req_o  output  1  instruction-memory request valid.
REQ-006 imem_addr_o  output  64  request address, equal to the current fetch PC.
REQ-007 imem_gnt_i  input  1  request accepted this cycle.
REQ-008 imem_rvalid_i  input  1  response valid; responses return in grant order, at least 1 cycle after grant.
REQ-009 imem_rdata_i  input  32  response instruction word.
REQ-010 redirect_i  input  1  control-flow redirect (branch/jump/trap) from downstream.
REQ-011 redirect_pc_i  input  64  redirect target.
REQ-012 instr_valid_o  output  1  head instruction available to decode.
REQ-013 instr_o  output  32  head instruction word, feeding decode and immediate generation.
REQ-014 pc_o  output  64  PC of instr_o.
REQ-015 instr_ready_i  input  1  decode accepts head; pop occurs on instr_valid_o && instr_ready_i.

Function
REQ-016 The block SHALL hold a fetch PC register pc_q; imem_addr_o SHALL equal pc_q.
REQ-017 Queue: DEPTH entries of {pc, instr, filled}, in order; an entry SHALL be allocated at grant, storing pc_q with filled=0.
REQ-018 imem_req_o SHALL be 1 iff !rst_i && !redirect_i && (allocated entries < DEPTH), evaluated from registered count only, with no combinational path from instr_ready_i.
REQ-019 On imem_req_o && imem_gnt_i: pc_q <= pc_q + 4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-020 On imem_rvalid_i with drop count 0: the oldest unfilled entry SHALL store imem_rdata_i and set filled=1.
REQ-021 instr_valid_o SHALL be 1 iff the head entry is allocated and filled; latency from rvalid to instr_valid_o is 1 cycle.
REQ-022 When instr_valid_o is 0, instr_o and pc_o SHALL be 0.
REQ-023 Allocation and pop in the same cycle SHALL both take effect, with count unchanged.
REQ-024 Fill and pop in the same cycle SHALL both take effect, on different or the same-index entries as ordering dictates.
REQ-025 Redirect: pc_q <= {redirect_pc_i[63:2], 2'b00}; all entries are freed; the drop counter is loaded with the number of granted-but-unfilled entries.
REQ-026 A response arriving in the redirect cycle SHALL be discarded and excluded from the loaded drop count.
REQ-027 A pop coinciding with redirect SHALL be ignored, since the flush wins.
REQ-028 While drop count > 0, each imem_rvalid_i SHALL be discarded and decrement the count; new requests are still issued, bounded by allocated entries + drop count < DEPTH.
REQ-029 imem_rvalid_i with no unfilled entry and drop count 0 is a protocol error; it SHALL be ignored, and the bench SHALL flag it.

Reset
REQ-030 While rst_i=1 at a clock edge, the block SHALL set pc_q=RESET_PC, free all entries, and set drop count=0.
REQ-031 During and immediately after reset, imem_req_o=0 and instr_valid_o=0; the first request SHALL occur in the cycle after rst_i deasserts, with imem_addr_o=RESET_PC.
REQ-032 Reset mid-operation SHALL discard all in-flight state with no output pulse; late responses after reset are the memory's responsibility to suppress.

Verification
REQ-033 Reset release, gnt=1 every cycle, rvalid 1 cycle later, ready=1 -> addresses 0,4,8,... are issued back-to-back; instr_o/pc_o pairs match in order.
REQ-034 ready=0 with DEPTH=2 -> exactly 2 grants (PC 0,4), then imem_req_o=0; raising ready pops entry PC 0 and re-enables the request the following cycle.
REQ-035 Two grants outstanding (PC 8,12), redirect_i=1 with target 64'h1003 -> the next request address is 64'h1000; both stale responses are dropped; the first instr_valid_o shows pc_o=64'h1000.
REQ-036 Redirect in the same cycle as rvalid and pop -> the response is discarded, the pop is ignored, and the queue is empty next cycle.
REQ-037 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> the second request address is 64'h0.
REQ-038 rst_i asserted with a full queue -> next cycle instr_valid_o=0 and imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/rv_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_if_stage
// Purpose  : Instruction-fetch stage. Issues sequential fetch requests from a
//            PC register, tracks in-flight fetches in an in-order queue, and
//            presents completed instructions to decode. Redirects flush the
//            queue and drop responses still owed for the flushed fetches.
// Ports    : clk_i/rst_i             clock, synchronous active-high reset
//            imem_req_o/imem_addr_o  fetch request valid / address (= pc)
//            imem_gnt_i              request accepted this cycle
//            imem_rvalid_i/rdata_i   in-order response and instruction word
//            redirect_i/redirect_pc_i control-flow redirect and target
//            instr_valid_o/instr_o/pc_o  head instruction to decode
//            instr_ready_i           decode accepts the head instruction
// Revision : 1.0  initial release
// ============================================================================
module rv_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2       // 2 or 4 (pointer math needs a power of two)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(DEPTH);

  logic [63:0]       r_pc;
  logic [63:0]       r_q_pc    [DEPTH];
  logic [31:0]       r_q_instr [DEPTH];
  logic [DEPTH-1:0]  r_q_filled;
  logic [IDX_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_count;    // allocated entries
  logic [CNT_W-1:0]  r_nfilled;  // filled entries; always the oldest ones
  logic [CNT_W-1:0]  r_drop;     // responses still owed to flushed fetches

  logic [IDX_W-1:0]  w_tail;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [CNT_W:0]    w_inflight;
  logic [CNT_W:0]    w_outstanding;
  logic [CNT_W-1:0]  w_drop_load;
  logic              w_valid;
  logic              w_req;
  logic              w_alloc;
  logic              w_fill;
  logic              w_discard;
  logic              w_pop;

  // Responses return in grant order, so the filled entries are always a
  // prefix of the queue and the oldest unfilled entry sits right after them.
  assign w_tail     = r_head + IDX_W'(r_count);
  assign w_fill_idx = r_head + IDX_W'(r_nfilled);

  // Dropped responses still occupy memory-side slots, so they count
  // against the request budget alongside allocated entries.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_drop};

  assign w_valid    = (r_count != '0) && r_q_filled[r_head];
  assign w_req      = !rst_i && !redirect_i && (w_inflight < c_depth);
  assign w_alloc    = w_req && imem_gnt_i;
  assign w_fill     = imem_rvalid_i && !redirect_i && (r_drop == '0) && (r_nfilled < r_count);
  assign w_discard  = imem_rvalid_i && !redirect_i && (r_drop != '0);
  assign w_pop      = w_valid && instr_ready_i && !redirect_i;

  // On redirect every granted-but-unanswered fetch becomes a drop; a
  // response landing in the redirect cycle itself is already discarded.
  assign w_outstanding = {1'b0, r_drop} + {1'b0, r_count - r_nfilled};
  assign w_drop_load   = (imem_rvalid_i && (w_outstanding != '0))
                         ? CNT_W'(w_outstanding - 1'b1)
                         : CNT_W'(w_outstanding);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_q_instr[r_head] : 32'h0;
  assign pc_o          = w_valid ? r_q_pc[r_head]    : 64'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_head     <= '0;
      r_count    <= '0;
      r_nfilled  <= '0;
      r_drop     <= '0;
      r_q_filled <= '0;
    end else if (redirect_i) begin
      r_pc       <= {redirect_pc_i[63:2], 2'b00};
      r_head     <= '0;
      r_count    <= '0;
      r_nfilled  <= '0;
      r_drop     <= w_drop_load;
      r_q_filled <= '0;
    end else begin
      if (w_alloc) begin
        r_pc               <= r_pc + 64'd4;
        r_q_filled[w_tail] <= 1'b0;
      end
      if (w_fill) begin
        r_q_filled[w_fill_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + IDX_W'(1);
      end
      if (w_discard) begin
        r_drop <= r_drop - CNT_W'(1);
      end
      r_count   <= r_count   + CNT_W'(w_alloc) - CNT_W'(w_pop);
      r_nfilled <= r_nfilled + CNT_W'(w_fill)  - CNT_W'(w_pop);
    end
  end

  // Payload storage needs no reset; it is only observed behind the filled
  // bit of an allocated entry.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_q_pc[w_tail] <= r_pc;
    end
    if (w_fill) begin
      r_q_instr[w_fill_idx] <= imem_rdata_i;
    end
  end

endmodule
`default_nettype wire
